// File: rtl/regaccess_pkg.sv
// Shared constants for the register-access SPI protocol: register map, frame layout
// and the initiator FSM state encoding.
package regaccess_pkg;

  localparam logic [6:0] REG_VERSION             = 7'h00;
  localparam logic [6:0] REG_STATUS_CONTROL      = 7'h01;
  localparam logic [6:0] REG_CHANNEL_SELECT_LOW  = 7'h02;
  localparam logic [6:0] REG_CHANNEL_SELECT_HIGH = 7'h03;
  localparam logic [6:0] REG_SAMPLE_RATE_DIVISOR = 7'h04;
  localparam logic [6:0] REG_LED_BRIGHTNESS      = 7'h05;
  localparam logic [6:0] REG_MODE                = 7'h0a;
  localparam logic [6:0] REG_SCRATCHPAD          = 7'h0d;

  localparam int         FRAME_BITS = 16;
  localparam int         RW_BIT     = 15;
  localparam logic [7:0] VERSION    = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period timebase: pulses tick every CLK_DIV enabled cycles; restart forces the
// count back to zero so the first half-period after a restart is full length.
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart)  cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/regaccess_spi_master.sv
// Mode-0 SPI initiator: one 16-bit {rw, regnum, data} frame per accepted start,
// returning the byte clocked in during the last 8 bits of a read.
module regaccess_spi_master
  import regaccess_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] regnum,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output state_e     dbg_state
);

  localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [4:0] TOG_LAST = 5'(2 * FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [7:0]            rx_q, rx_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [4:0]            tog_q, tog_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ss_q, ss_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  accept;
  logic                  tick;

  assign accept = (state_q == ST_IDLE) && start && !busy_q;

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != ST_IDLE),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    tog_d   = tog_q;
    gap_d   = gap_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sh_d    = {rw, regnum, (rw ? wdata : 8'h00)};
          rw_d    = rw;
          ss_d    = 1'b0;
          mosi_d  = rw;
          busy_d  = 1'b1;
          tog_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 5'd1;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], miso};
          end else if (tog_q == TOG_LAST) begin
            state_d = ST_HOLD;
          end else begin
            // Next bit goes out on the falling edge, a full half-period before the slave samples it.
            sh_d   = sh_q << 1;
            mosi_d = sh_q[FRAME_BITS-2];
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(SS_GAP - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (!rw_q) rdata_d = rx_q;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= 8'h00;
      tog_q   <= '0;
      gap_q   <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      tog_q   <= tog_d;
      gap_q   <= gap_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign ss        = ss_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regaccess_spi_master.sv
// Bench for regaccess_spi_master against a behavioural mode-0 regfile slave; expected
// rdata, mosi frames and latencies are queued at issue and checked by monitors.
module tb_regaccess_spi_master;
  import regaccess_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int SS_GAP  = 4;
  localparam int LAT     = CLK_DIV * 34 + SS_GAP + 1;  // 73
  localparam int SS_LOW  = CLK_DIV * 34;               // 68

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] regnum = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, ss, sclk, mosi;
  logic       miso = 1'b0;
  logic [7:0] rdata;
  state_e     dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regaccess_spi_master #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .regnum(regnum), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ss(ss), .sclk(sclk), .mosi(mosi),
    .miso(miso), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_frame_q[$];
  int          start_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  logic [7:0]  regs[16];
  logic [15:0] s_shift;
  logic [7:0]  s_tx;
  int          s_cnt = 0;
  int          frames = 0;

  initial for (int i = 0; i < 16; i++) regs[i] = 8'h00;

  function automatic logic [7:0] slave_read(input logic [6:0] a);
    if (a == REG_VERSION)        return VERSION;
    if (a == REG_STATUS_CONTROL) return regs[1] | 8'h04;  // ready flag always set
    return regs[a[3:0]];
  endfunction

  always @(negedge ss) begin
    s_cnt = 0;
    s_shift = '0;
    miso = 1'b0;
  end

  always @(posedge sclk) if (!ss) begin
    s_shift = {s_shift[14:0], mosi};
    s_cnt++;
    if (s_cnt == 8) s_tx = slave_read(s_shift[6:0]);
  end

  always @(negedge sclk) if (!ss && s_cnt >= 8 && s_cnt < 16) begin
    miso = s_tx[7];
    s_tx = {s_tx[6:0], 1'b0};
  end

  always @(posedge ss) begin
    if (s_cnt == 16) begin
      frames++;
      if (exp_frame_q.size() == 0) check("unexpected_frame", s_shift, 32'hdead);
      else check("mosi_frame", s_shift, exp_frame_q.pop_front());
      if (s_shift[15] && s_shift[14:8] != REG_VERSION) regs[s_shift[11:8]] = s_shift[7:0];
    end
    s_cnt = 0;
    miso = 1'b0;
  end

  // ---------------- monitor ----------------
  int ss_low_run = 0;
  int ss_high_run = 0;
  bit chk_gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ss_low_run = 0;
      ss_high_run = 0;
    end else begin
      if (!ss) begin
        // Gap spans the GAP phase plus the done cycle in which the next start is accepted.
        if (ss_high_run > 0 && chk_gap) check("ss_high_gap", ss_high_run, SS_GAP + 1);
        ss_high_run = 0;
        ss_low_run++;
      end else begin
        if (ss_low_run > 0) check("ss_low_cycles", ss_low_run, SS_LOW);
        ss_low_run = 0;
        ss_high_run++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
          check("busy_at_done", busy, 0);
          check("latency", cyc - start_q.pop_front(), LAT);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, output int acc);
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) check("issue_wait_timeout", 1, 0);
    start = 1'b1; rw = r; regnum = a; wdata = d;
    acc = cyc;
    exp_q.push_back(exp_rd);
    exp_frame_q.push_back({r, a, (r ? d : 8'h00)});
    start_q.push_back(acc);
    @(negedge clk);
    start = 1'b0; rw = ~r; regnum = ~a; wdata = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("done_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, f0, nd, n;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write scratchpad, rdata must stay at reset value
    issue(1'b1, REG_SCRATCHPAD, 8'h5a, 8'h00, acc);
    wait_done();
    // 2: read version
    issue(1'b0, REG_VERSION, 8'h00, 8'h10, acc);
    wait_done();
    // 3: write then read status/control
    issue(1'b1, REG_STATUS_CONTROL, 8'h41, 8'h10, acc);
    wait_done();
    issue(1'b0, REG_STATUS_CONTROL, 8'h00, 8'h45, acc);
    wait_done();

    // 4: start pulses mid-frame are ignored
    f0 = frames;
    issue(1'b0, REG_VERSION, 8'h00, 8'h10, acc);
    repeat (4) @(negedge clk);
    start = 1'b1; rw = 1'b1; regnum = REG_SCRATCHPAD; wdata = 8'hff;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (80) @(negedge clk);
    check("ignored_start_frames", frames - f0, 1);

    // 5: reset mid-frame
    issue(1'b0, REG_VERSION, 8'h00, 8'h10, acc);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ss", ss, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 8'h00);
    exp_q.delete();
    exp_frame_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, REG_STATUS_CONTROL, 8'h00, 8'h45, acc);
    wait_done();

    issue(1'b1, REG_SCRATCHPAD, 8'h73, 8'h45, acc);
    wait_done();

    // 6: start held high, three back-to-back reads of scratchpad
    @(negedge clk);
    start = 1'b1; rw = 1'b0; regnum = REG_SCRATCHPAD; wdata = 8'h00;
    acc = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h73);
      exp_frame_q.push_back(16'h0d00);
      start_q.push_back(acc + i * LAT);
    end
    nd = 0; n = 0;
    while (nd < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (done) begin
        nd++;
        if (nd == 1) chk_gap = 1;
      end
    end
    start = 1'b0;
    chk_gap = 0;
    if (nd < 3) check("b2b_timeout", nd, 3);
    wait_done();
    repeat (10) @(negedge clk);

    check("total_frames", frames, 10);
    check("pending_expect", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
